// File: rtl/vec_alu_pipe.sv
// Two-stage vector execute ALU: X computes (or iterates the divider), X2 holds
// the result and muxes in load data, with valid/ready flow control both sides.
module vec_alu_pipe #(
    parameter int WIDTH = 16,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_pc,
    input  logic [15:0]            in_ins,
    input  logic [LANES*WIDTH-1:0] in_op1,
    input  logic [LANES*WIDTH-1:0] in_op2,
    input  logic [LANES*WIDTH-1:0] mem_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_result,
    output logic [LANES*WIDTH-1:0] out_aux,
    output logic [15:0]            out_ins,
    output logic [WIDTH-1:0]       out_pc,
    output logic                   busy
);

    localparam int VW = LANES * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        X_EMPTY,
        X_FULL,
        X_DIV
    } x_state_t;

    x_state_t         x_state_q, x_state_d;
    logic [CW-1:0]    div_cnt_q, div_cnt_d;
    logic [WIDTH-1:0] x_pc_q, x_pc_d;
    logic [15:0]      x_ins_q, x_ins_d;
    logic [VW-1:0]    x_res_q, x_res_d;
    logic [VW-1:0]    x_aux_q, x_aux_d;
    logic [VW-1:0]    x_dsr_q, x_dsr_d;

    logic             x2_valid_q, x2_valid_d;
    logic [WIDTH-1:0] x2_pc_q, x2_pc_d;
    logic [15:0]      x2_ins_q, x2_ins_d;
    logic [VW-1:0]    x2_res_q, x2_res_d;
    logic [VW-1:0]    x2_aux_q, x2_aux_d;

    logic [3:0]       in_opc;
    logic [3:0]       in_sub;
    logic [7:0]       in_ival;
    logic             in_is_div;
    logic             advance;
    logic             accept;

    logic [VW-1:0]    calc_res;
    logic [VW-1:0]    calc_aux;
    logic [VW-1:0]    step_quo;
    logic [VW-1:0]    step_rem;
    logic [VW-1:0]    lane0_mask;

    logic [3:0]       x2_opc;
    logic [3:0]       x2_sub;

    assign in_opc    = in_ins[15:12];
    assign in_sub    = in_ins[7:4];
    assign in_ival   = in_ins[11:4];
    assign in_is_div = (in_opc == 4'h3) || (in_opc == 4'hB);

    assign advance  = (x_state_q == X_FULL) && (!x2_valid_q || out_ready);
    assign in_ready = (x_state_q == X_EMPTY) || advance;
    assign accept   = in_valid && in_ready;
    assign busy     = (x_state_q == X_DIV);

    assign lane0_mask = VW'({WIDTH{1'b1}});

    // Single-cycle result for every non-divide opcode, computed from the inputs
    always_comb begin
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [WIDTH-1:0]   a0;
        logic [WIDTH-1:0]   b0;
        logic [2*WIDTH-1:0] prod;
        logic [2*WIDTH-1:0] prod0;
        logic [WIDTH-1:0]   dot_acc;
        logic               cond_ok;

        calc_res = '0;
        calc_aux = '0;
        a        = '0;
        b        = '0;
        prod     = '0;
        dot_acc  = '0;
        cond_ok  = 1'b0;
        a0       = in_op1[WIDTH-1:0];
        b0       = in_op2[WIDTH-1:0];
        prod0    = {{WIDTH{1'b0}}, a0} * {{WIDTH{1'b0}}, b0};

        for (int i = 0; i < LANES; i++) begin
            a       = in_op1[i*WIDTH +: WIDTH];
            b       = in_op2[i*WIDTH +: WIDTH];
            prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
            dot_acc = dot_acc + prod[WIDTH-1:0];
            case (in_opc)
                4'h8: calc_res[i*WIDTH +: WIDTH] = a + b;
                4'h9: calc_res[i*WIDTH +: WIDTH] = a - b;
                4'hA: begin
                    calc_res[i*WIDTH +: WIDTH] = prod[WIDTH-1:0];
                    calc_aux[i*WIDTH +: WIDTH] = prod[2*WIDTH-1:WIDTH];
                end
                4'hD: calc_res[i*WIDTH +: WIDTH] = a;
                default: ;
            endcase
        end

        case (in_sub)
            4'h0:    cond_ok = (a0 == '0);
            4'h1:    cond_ok = (a0 != '0);
            4'h2:    cond_ok = a0[WIDTH-1];
            4'h3:    cond_ok = !a0[WIDTH-1];
            default: cond_ok = 1'b0;
        endcase

        // Scalar opcodes only ever populate lane 0
        case (in_opc)
            4'h0: calc_res[WIDTH-1:0] = a0 + b0;
            4'h1: calc_res[WIDTH-1:0] = a0 - b0;
            4'h2: begin
                calc_res[WIDTH-1:0] = prod0[WIDTH-1:0];
                calc_aux[WIDTH-1:0] = prod0[2*WIDTH-1:WIDTH];
            end
            4'h4: calc_res[WIDTH-1:0] = WIDTH'($signed(in_ival));
            4'h5: calc_res[WIDTH-1:0] = WIDTH'({in_ival, b0[7:0]});
            4'h6: begin
                if (in_sub <= 4'h3) begin
                    calc_res[WIDTH-1:0] = cond_ok ? b0 : (in_pc + WIDTH'(2));
                end
            end
            4'h7: begin
                if (in_sub == 4'h1) begin
                    calc_res[WIDTH-1:0] = a0;
                end
            end
            4'hE: calc_res[WIDTH-1:0] = dot_acc;
            default: ;
        endcase
    end

    // One restoring-division step per lane; a zero divisor naturally yields
    // an all-ones quotient and leaves the dividend as the remainder
    always_comb begin
        logic [WIDTH-1:0] quo;
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] dsr;
        logic [WIDTH:0]   trial;
        logic             qbit;

        step_quo = '0;
        step_rem = '0;
        quo      = '0;
        rem      = '0;
        dsr      = '0;
        trial    = '0;
        qbit     = 1'b0;

        for (int i = 0; i < LANES; i++) begin
            quo   = x_res_q[i*WIDTH +: WIDTH];
            rem   = x_aux_q[i*WIDTH +: WIDTH];
            dsr   = x_dsr_q[i*WIDTH +: WIDTH];
            trial = {rem, quo[WIDTH-1]};
            if (trial >= {1'b0, dsr}) begin
                trial = trial - {1'b0, dsr};
                qbit  = 1'b1;
            end else begin
                qbit  = 1'b0;
            end
            step_quo[i*WIDTH +: WIDTH] = {quo[WIDTH-2:0], qbit};
            step_rem[i*WIDTH +: WIDTH] = trial[WIDTH-1:0];
        end
    end

    // X stage: accept, iterate the divider, or drain into X2
    always_comb begin
        x_state_d = x_state_q;
        div_cnt_d = div_cnt_q;
        x_pc_d    = x_pc_q;
        x_ins_d   = x_ins_q;
        x_res_d   = x_res_q;
        x_aux_d   = x_aux_q;
        x_dsr_d   = x_dsr_q;

        if (accept) begin
            x_pc_d  = in_pc;
            x_ins_d = in_ins;
            if (in_is_div) begin
                x_state_d = X_DIV;
                div_cnt_d = CW'(WIDTH);
                x_res_d   = in_op1;
                x_aux_d   = '0;
                x_dsr_d   = in_op2;
            end else begin
                x_state_d = X_FULL;
                x_res_d   = calc_res;
                x_aux_d   = calc_aux;
            end
        end else if (advance) begin
            x_state_d = X_EMPTY;
        end else if (x_state_q == X_DIV) begin
            x_res_d   = step_quo;
            x_aux_d   = step_rem;
            div_cnt_d = div_cnt_q - CW'(1);
            if (div_cnt_q == CW'(1)) begin
                x_state_d = X_FULL;
                if (x_ins_q[15:12] == 4'h3) begin
                    x_res_d = step_quo & lane0_mask;
                    x_aux_d = step_rem & lane0_mask;
                end
            end
        end
    end

    // X2 stage: load on advance, otherwise hold until downstream takes it
    always_comb begin
        x2_valid_d = x2_valid_q;
        x2_pc_d    = x2_pc_q;
        x2_ins_d   = x2_ins_q;
        x2_res_d   = x2_res_q;
        x2_aux_d   = x2_aux_q;

        if (advance) begin
            x2_valid_d = 1'b1;
            x2_pc_d    = x_pc_q;
            x2_ins_d   = x_ins_q;
            x2_res_d   = x_res_q;
            x2_aux_d   = x_aux_q;
        end else if (out_ready) begin
            x2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_state_q  <= X_EMPTY;
            div_cnt_q  <= '0;
            x_pc_q     <= '0;
            x_ins_q    <= '0;
            x_res_q    <= '0;
            x_aux_q    <= '0;
            x_dsr_q    <= '0;
            x2_valid_q <= 1'b0;
            x2_pc_q    <= '0;
            x2_ins_q   <= '0;
            x2_res_q   <= '0;
            x2_aux_q   <= '0;
        end else begin
            x_state_q  <= x_state_d;
            div_cnt_q  <= div_cnt_d;
            x_pc_q     <= x_pc_d;
            x_ins_q    <= x_ins_d;
            x_res_q    <= x_res_d;
            x_aux_q    <= x_aux_d;
            x_dsr_q    <= x_dsr_d;
            x2_valid_q <= x2_valid_d;
            x2_pc_q    <= x2_pc_d;
            x2_ins_q   <= x2_ins_d;
            x2_res_q   <= x2_res_d;
            x2_aux_q   <= x2_aux_d;
        end
    end

    assign x2_opc = x2_ins_q[15:12];
    assign x2_sub = x2_ins_q[7:4];

    // Load data bypasses the X2 register and follows mem_data directly
    always_comb begin
        out_result = x2_res_q;
        if (x2_opc == 4'hC) begin
            out_result = mem_data;
        end else if ((x2_opc == 4'h7) && (x2_sub == 4'h0)) begin
            out_result = mem_data & lane0_mask;
        end
    end

    assign out_valid = x2_valid_q;
    assign out_aux   = x2_aux_q;
    assign out_ins   = x2_ins_q;
    assign out_pc    = x2_pc_q;

endmodule
